// File: rtl/trap_unit.sv
// Machine-mode trap controller: latches exceptions/interrupts, owns the M-mode CSRs, supplies trap/return PC.
// Optional build macro TRAP_VECTORED_EN enables vectored interrupt dispatch through mtvec.MODE.
module trap_unit #(
  parameter logic [31:0] MTVEC_RESET     = 32'h0000_0000,
  parameter int          IRQ_SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc,
  input  logic [31:0] inst,
  input  logic [31:0] inst_addr,
  input  logic [31:0] data_addr,
  input  logic        illegal_inst,
  input  logic        inst_addr_misalign,
  input  logic        load_addr_misalign,
  input  logic        store_addr_misalign,
  input  logic        env_call,
  input  logic        env_break,
  input  logic        irq_ext,
  input  logic        irq_timer,
  input  logic        irq_soft,
  input  logic        trap_start,
  input  logic        trap_finish,
  output logic        trap_pending,
  output logic [31:0] trap_cause,
  output logic [31:0] trap_pc,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  input  logic        csr_write,
  output logic [31:0] csr_rdata
);

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_MIP      = 12'h344;

  function automatic logic [31:0] mtvec_legal(input logic [31:0] v);
`ifdef TRAP_VECTORED_EN
    return {v[31:2], 1'b0, (v[1:0] == 2'b01)};
`else
    return {v[31:2], 2'b00};
`endif
  endfunction

  // Packs {ext,timer,soft} into the architectural bit positions 11/7/3.
  function automatic logic [31:0] irq_bits(input logic [2:0] v);
    return {20'b0, v[2], 3'b0, v[1], 3'b0, v[0], 3'b0};
  endfunction

  logic [2:0]  irq_sync_q [IRQ_SYNC_STAGES];
  logic [2:0]  irq_s;
  logic        pending_q, pending_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] mtval_q, mtval_d;
  logic        mstatus_mie_q, mstatus_mie_d;
  logic        mstatus_mpie_q, mstatus_mpie_d;
  logic [2:0]  csr_mie_q, csr_mie_d;
  logic [31:0] csr_mtvec_q, csr_mtvec_d;
  logic [31:0] csr_mscratch_q, csr_mscratch_d;
  logic [31:0] csr_mepc_q, csr_mepc_d;
  logic [31:0] csr_mcause_q, csr_mcause_d;
  logic [31:0] csr_mtval_q, csr_mtval_d;

  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_tval;
  logic [2:0]  irq_hit;
  logic        irq_valid;
  logic [4:0]  irq_code;
  logic [31:0] vec_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < IRQ_SYNC_STAGES; i++) irq_sync_q[i] <= '0;
    end else begin
      irq_sync_q[0] <= {irq_ext, irq_timer, irq_soft};
      for (int i = 1; i < IRQ_SYNC_STAGES; i++) irq_sync_q[i] <= irq_sync_q[i-1];
    end
  end

  assign irq_s = irq_sync_q[IRQ_SYNC_STAGES-1];

  always_comb begin
    exc_valid = 1'b1;
    exc_code  = 5'd0;
    exc_tval  = 32'h0;
    if (inst_addr_misalign) begin
      exc_code = 5'd0;  exc_tval = inst_addr;
    end else if (illegal_inst) begin
      exc_code = 5'd2;  exc_tval = inst;
    end else if (env_break) begin
      exc_code = 5'd3;  exc_tval = pc;
    end else if (env_call) begin
      exc_code = 5'd11; exc_tval = 32'h0;
    end else if (load_addr_misalign) begin
      exc_code = 5'd4;  exc_tval = data_addr;
    end else if (store_addr_misalign) begin
      exc_code = 5'd6;  exc_tval = data_addr;
    end else begin
      exc_valid = 1'b0;
    end
  end

  assign irq_hit   = irq_s & csr_mie_q;
  assign irq_valid = mstatus_mie_q && (irq_hit != 3'b000);
  assign irq_code  = irq_hit[2] ? 5'd11 : (irq_hit[0] ? 5'd3 : 5'd7);

  always_comb begin
    pending_d = pending_q;
    cause_d   = cause_q;
    mtval_d   = mtval_q;
    if (trap_start) begin
      pending_d = 1'b0;
    end else if (!pending_q) begin
      if (exc_valid) begin
        pending_d = 1'b1;
        cause_d   = {27'b0, exc_code};
        mtval_d   = exc_tval;
      end else if (irq_valid) begin
        pending_d = 1'b1;
        cause_d   = {1'b1, 26'b0, irq_code};
        mtval_d   = 32'h0;
      end
    end
  end

  always_comb begin
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    csr_mie_d      = csr_mie_q;
    csr_mtvec_d    = csr_mtvec_q;
    csr_mscratch_d = csr_mscratch_q;
    csr_mepc_d     = csr_mepc_q;
    csr_mcause_d   = csr_mcause_q;
    csr_mtval_d    = csr_mtval_q;
    if (csr_write && !trap_start) begin
      case (csr_addr)
        CSR_MSTATUS:  begin
          mstatus_mie_d  = csr_wdata[3];
          mstatus_mpie_d = csr_wdata[7];
        end
        CSR_MIE:      csr_mie_d      = {csr_wdata[11], csr_wdata[7], csr_wdata[3]};
        CSR_MTVEC:    csr_mtvec_d    = mtvec_legal(csr_wdata);
        CSR_MSCRATCH: csr_mscratch_d = csr_wdata;
        CSR_MEPC:     csr_mepc_d     = {csr_wdata[31:2], 2'b00};
        CSR_MCAUSE:   csr_mcause_d   = csr_wdata;
        CSR_MTVAL:    csr_mtval_d    = csr_wdata;
        default: ;
      endcase
    end
    if (trap_start) begin
      csr_mepc_d     = {pc[31:2], 2'b00};
      csr_mcause_d   = cause_q;
      csr_mtval_d    = mtval_q;
      mstatus_mpie_d = mstatus_mie_q;
      mstatus_mie_d  = 1'b0;
    end else if (trap_finish && !pending_q) begin
      // A trap latched during MRET takes precedence; the FSM re-enters TRAP instead.
      mstatus_mie_d  = mstatus_mpie_q;
      mstatus_mpie_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q      <= 1'b0;
      cause_q        <= 32'h0;
      mtval_q        <= 32'h0;
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      csr_mie_q      <= 3'b000;
      csr_mtvec_q    <= mtvec_legal(MTVEC_RESET);
      csr_mscratch_q <= 32'h0;
      csr_mepc_q     <= 32'h0;
      csr_mcause_q   <= 32'h0;
      csr_mtval_q    <= 32'h0;
    end else begin
      pending_q      <= pending_d;
      cause_q        <= cause_d;
      mtval_q        <= mtval_d;
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      csr_mie_q      <= csr_mie_d;
      csr_mtvec_q    <= csr_mtvec_d;
      csr_mscratch_q <= csr_mscratch_d;
      csr_mepc_q     <= csr_mepc_d;
      csr_mcause_q   <= csr_mcause_d;
      csr_mtval_q    <= csr_mtval_d;
    end
  end

  always_comb begin
    vec_pc = {csr_mtvec_q[31:2], 2'b00};
`ifdef TRAP_VECTORED_EN
    if (csr_mtvec_q[1:0] == 2'b01 && cause_q[31])
      vec_pc = {csr_mtvec_q[31:2], 2'b00} + {cause_q[29:0], 2'b00};
`endif
  end

  assign trap_pending = pending_q & ~trap_start;
  assign trap_cause   = cause_q;
  assign trap_pc      = trap_start ? vec_pc : (trap_finish ? csr_mepc_q : 32'h0);

  always_comb begin
    csr_rdata = 32'h0;
    case (csr_addr)
      CSR_MSTATUS:  csr_rdata = {19'b0, 2'b11, 3'b0, mstatus_mpie_q, 3'b0, mstatus_mie_q, 3'b0};
      CSR_MIE:      csr_rdata = irq_bits(csr_mie_q);
      CSR_MTVEC:    csr_rdata = csr_mtvec_q;
      CSR_MSCRATCH: csr_rdata = csr_mscratch_q;
      CSR_MEPC:     csr_rdata = csr_mepc_q;
      CSR_MCAUSE:   csr_rdata = csr_mcause_q;
      CSR_MTVAL:    csr_rdata = csr_mtval_q;
      CSR_MIP:      csr_rdata = irq_bits(irq_s);
      default:      csr_rdata = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_trap_unit.sv
// Directed bench for trap_unit: expected values queued at stimulus time, popped and asserted at sample time.
module tb_trap_unit;
  localparam logic [31:0] MTVEC_RST = 32'h0000_0080;
  localparam int          SYNC      = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc, inst, inst_addr, data_addr;
  logic        illegal_inst, inst_addr_misalign, load_addr_misalign, store_addr_misalign;
  logic        env_call, env_break, irq_ext, irq_timer, irq_soft;
  logic        trap_start, trap_finish, trap_pending, csr_write;
  logic [31:0] trap_cause, trap_pc, csr_wdata, csr_rdata;
  logic [11:0] csr_addr;

  logic [31:0] exp_q[$];
  string       tag_q[$];
  int          vectors = 0;
  int          miscompares = 0;

  trap_unit #(.MTVEC_RESET(MTVEC_RST), .IRQ_SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .inst(inst), .inst_addr(inst_addr), .data_addr(data_addr),
    .illegal_inst(illegal_inst), .inst_addr_misalign(inst_addr_misalign),
    .load_addr_misalign(load_addr_misalign), .store_addr_misalign(store_addr_misalign),
    .env_call(env_call), .env_break(env_break),
    .irq_ext(irq_ext), .irq_timer(irq_timer), .irq_soft(irq_soft),
    .trap_start(trap_start), .trap_finish(trap_finish),
    .trap_pending(trap_pending), .trap_cause(trap_cause), .trap_pc(trap_pc),
    .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_write(csr_write), .csr_rdata(csr_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_v(input string tag, input logic [31:0] v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic check(input logic [31:0] obs);
    logic [31:0] e;
    string       t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    vectors++;
    assert (obs === e) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", t, obs, e);
    end
  endtask

  task automatic rd(input logic [11:0] a, input string tag, input logic [31:0] v);
    expect_v(tag, v);
    csr_addr = a;
    #1;
    check(csr_rdata);
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    csr_addr  = a;
    csr_wdata = d;
    csr_write = 1'b1;
    tick();
    csr_write = 1'b0;
  endtask

  task automatic start_trap(input string tag, input logic [31:0] exp_pc);
    expect_v({tag, "_pc"}, exp_pc);
    expect_v({tag, "_pend_drop"}, 32'h0);
    trap_start = 1'b1;
    #1;
    check(trap_pc);
    check({31'b0, trap_pending});
    tick();
    trap_start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    pc = 32'h0; inst = 32'h0; inst_addr = 32'h0; data_addr = 32'h0;
    illegal_inst = 0; inst_addr_misalign = 0; load_addr_misalign = 0; store_addr_misalign = 0;
    env_call = 0; env_break = 0; irq_ext = 0; irq_timer = 0; irq_soft = 0;
    trap_start = 0; trap_finish = 0; csr_write = 0; csr_wdata = 0; csr_addr = 12'h0;
    tick(); tick();
    expect_v("rst_pending", 32'h0);
    check({31'b0, trap_pending});
    expect_v("rst_cause", 32'h0);
    check(trap_cause);
    expect_v("rst_trap_pc", 32'h0);
    check(trap_pc);
    rd(12'h305, "rst_mtvec", MTVEC_RST);
    rd(12'h300, "rst_mstatus", 32'h0000_1800);
    rst_n = 1'b1;
    tick();

    wr(12'h305, 32'h0000_0200);
    wr(12'h300, 32'h0000_0008);
    rd(12'h305, "mtvec_wr", 32'h0000_0200);
    wr(12'h340, 32'hCAFE_F00D);
    rd(12'h340, "mscratch", 32'hCAFE_F00D);
    wr(12'h7C0, 32'h1234_5678);
    rd(12'h7C0, "unmapped", 32'h0);

    // ecall
    pc = 32'h100; env_call = 1'b1;
    tick();
    env_call = 1'b0;
    expect_v("ecall_pending", 32'h1);
    check({31'b0, trap_pending});
    expect_v("ecall_cause", 32'd11);
    check(trap_cause);
    start_trap("ecall", 32'h200);
    rd(12'h341, "ecall_mepc", 32'h100);
    rd(12'h342, "ecall_mcause", 32'd11);
    rd(12'h343, "ecall_mtval", 32'h0);
    rd(12'h300, "ecall_mstatus", 32'h0000_1880);

    // illegal instruction
    inst = 32'hFFFF_FFFF; illegal_inst = 1'b1;
    tick();
    illegal_inst = 1'b0;
    expect_v("illegal_cause", 32'd2);
    check(trap_cause);
    start_trap("illegal", 32'h200);
    rd(12'h342, "illegal_mcause", 32'd2);
    rd(12'h343, "illegal_mtval", 32'hFFFF_FFFF);

    // load misalign with unaligned pc
    pc = 32'h106; data_addr = 32'h1003; load_addr_misalign = 1'b1;
    tick();
    load_addr_misalign = 1'b0;
    start_trap("load", 32'h200);
    rd(12'h342, "load_mcause", 32'd4);
    rd(12'h343, "load_mtval", 32'h1003);
    rd(12'h341, "load_mepc", 32'h104);

    // priority: inst misalign beats illegal
    inst_addr = 32'h0000_0456; inst_addr_misalign = 1'b1; illegal_inst = 1'b1;
    tick();
    inst_addr_misalign = 1'b0; illegal_inst = 1'b0;
    expect_v("prio_cause", 32'd0);
    check(trap_cause);
    start_trap("prio", 32'h200);
    rd(12'h343, "prio_mtval", 32'h0000_0456);

    // MRET
    wr(12'h341, 32'h0000_0104);
    wr(12'h300, 32'h0000_0080);
    expect_v("mret_pc", 32'h104);
    trap_finish = 1'b1;
    #1;
    check(trap_pc);
    tick();
    trap_finish = 1'b0;
    rd(12'h300, "mret_mstatus", 32'h0000_1888);

    // timer interrupt latency
    wr(12'h304, 32'h0000_0080);
    irq_timer = 1'b1;
    for (int i = 1; i <= SYNC + 1; i++) begin
      tick();
      expect_v($sformatf("irq_lat_%0d", i), (i == SYNC + 1) ? 32'h1 : 32'h0);
      check({31'b0, trap_pending});
    end
    expect_v("irq_timer_cause", 32'h8000_0007);
    check(trap_cause);
    start_trap("timer", 32'h200);

    // MIE now 0: level still high must not trap
    for (int i = 0; i < 4; i++) tick();
    expect_v("mie0_no_pending", 32'h0);
    check({31'b0, trap_pending});
    rd(12'h344, "mip_timer", 32'h0000_0080);
    irq_timer = 1'b0;
    wr(12'h304, 32'h0);
    wr(12'h300, 32'h0000_0008);

    // exception beats synced interrupt
    irq_ext = 1'b1;
    for (int i = 0; i < SYNC + 1; i++) tick();
    rd(12'h344, "mip_ext", 32'h0000_0800);
    expect_v("ext_masked", 32'h0);
    check({31'b0, trap_pending});
    wr(12'h304, 32'h0000_0800);
    data_addr = 32'h2001; load_addr_misalign = 1'b1;
    tick();
    load_addr_misalign = 1'b0;
    expect_v("exc_vs_irq_cause", 32'd4);
    check(trap_cause);
    start_trap("exc_vs_irq", 32'h200);
    for (int i = 0; i < 3; i++) tick();
    expect_v("irq_masked_after_trap", 32'h0);
    check({31'b0, trap_pending});
    trap_finish = 1'b1;
    tick();
    trap_finish = 1'b0;
    tick();
    expect_v("mret_irq_pending", 32'h1);
    check({31'b0, trap_pending});
    expect_v("mret_irq_cause", 32'h8000_000B);
    check(trap_cause);

    // a later exception is ignored while pending
    env_call = 1'b1;
    tick();
    env_call = 1'b0;
    expect_v("first_wins", 32'h8000_000B);
    check(trap_cause);

    wr(12'h305, 32'h0000_0201);
`ifdef TRAP_VECTORED_EN
    rd(12'h305, "mtvec_mode", 32'h0000_0201);
    start_trap("vectored", 32'h0000_022C);
`else
    rd(12'h305, "mtvec_mode", 32'h0000_0200);
    start_trap("vectored", 32'h0000_0200);
`endif
    irq_ext = 1'b0;
    for (int i = 0; i < SYNC + 1; i++) tick();

    // MRET while pending: no restore
    rd(12'h300, "pre_finish_mstatus", 32'h0000_1880);
    env_break = 1'b1; pc = 32'h0000_0300;
    tick();
    env_break = 1'b0;
    trap_finish = 1'b1;
    tick();
    trap_finish = 1'b0;
    rd(12'h300, "finish_pending_mstatus", 32'h0000_1880);
    expect_v("ebreak_cause", 32'd3);
    check(trap_cause);

    // async reset mid-pending
    rst_n = 1'b0;
    #1;
    expect_v("rst_mid_pending", 32'h0);
    check({31'b0, trap_pending});
    expect_v("rst_mid_cause", 32'h0);
    check(trap_cause);
    rd(12'h305, "rst_mid_mtvec", MTVEC_RST);
    tick();
    rst_n = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
